// File: rtl/wb_interconnect_arb_wrr_if.sv
// Request/grant bundle between Wishbone initiators and the weighted round-robin arbiter.
// master = initiator/target side that drives req/weight/ack; slave = the arbiter.
interface wb_interconnect_arb_wrr_if #(
   parameter int N_REQ    = 4,
   parameter int WEIGHT_W = 4,
   parameter int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
   logic [N_REQ-1:0]          req;
   logic [N_REQ*WEIGHT_W-1:0] weight;
   logic                      ack;
   logic [N_REQ-1:0]          gnt;
   logic [IDX_W-1:0]          gnt_idx;
   logic                      gnt_valid;
   logic                      timeout;

   modport master (
      output req, weight, ack,
      input  gnt, gnt_idx, gnt_valid, timeout
   );

   modport slave (
      input  req, weight, ack,
      output gnt, gnt_idx, gnt_valid, timeout
   );
endinterface

// File: rtl/wb_interconnect_arb_wrr.sv
// Weighted round-robin Wishbone arbiter: 1-cycle req->gnt, grant held for up to weight acked
// transfers, one idle turnaround cycle per release; optional watchdog under ARB_TIMEOUT_EN.
module wb_interconnect_arb_wrr #(
   parameter int N_REQ    = 4,
   parameter int WEIGHT_W = 4,
   parameter int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   parameter int TIMEOUT  = 256
) (
   input  logic                     clock,
   input  logic                     reset,
   wb_interconnect_arb_wrr_if.slave bus
);
   typedef enum logic {IDLE, GRANT} state_t;

   state_t              r_state, w_state_nxt;
   logic [IDX_W-1:0]    r_last, w_last_nxt;
   logic [WEIGHT_W-1:0] r_quota, w_quota_nxt;
   logic [IDX_W-1:0]    w_win, w_cand;
   logic                w_any;
   logic [WEIGHT_W-1:0] w_wsel;
   logic                w_own_req;
   logic                w_release;
`ifdef ARB_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TO_W-1:0]     r_wdog, w_wdog_nxt;
   logic                r_timeout, w_to_fire;
`endif

   // Search starts one past the previous owner so the last winner goes to the back.
   always_comb begin
      w_win  = '0;
      w_any  = 1'b0;
      w_cand = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         w_cand = IDX_W'((int'(r_last) + k) % N_REQ);
         if (bus.req[w_cand]) begin
            w_any = 1'b1;
            w_win = w_cand;
         end
      end
      w_wsel    = bus.weight[int'(w_win)*WEIGHT_W +: WEIGHT_W];
      w_own_req = bus.req[r_last];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_last  <= IDX_W'(N_REQ - 1);
         r_quota <= '0;
`ifdef ARB_TIMEOUT_EN
         r_wdog    <= '0;
         r_timeout <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         r_quota <= w_quota_nxt;
`ifdef ARB_TIMEOUT_EN
         r_wdog    <= w_wdog_nxt;
         r_timeout <= w_to_fire;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_quota_nxt = r_quota;
      w_release   = 1'b0;
`ifdef ARB_TIMEOUT_EN
      w_wdog_nxt = r_wdog;
      w_to_fire  = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = GRANT;
               w_last_nxt  = w_win;
               w_quota_nxt = (w_wsel == '0) ? WEIGHT_W'(1) : w_wsel;
`ifdef ARB_TIMEOUT_EN
               w_wdog_nxt = '0;
`endif
            end
         end
         GRANT: begin
            if (bus.ack)
               w_quota_nxt = r_quota - WEIGHT_W'(1);
            // A counted ack and a dropped req both release; either beats the watchdog.
            w_release = !w_own_req || (bus.ack && r_quota == WEIGHT_W'(1));
`ifdef ARB_TIMEOUT_EN
            w_wdog_nxt = bus.ack ? '0 : r_wdog + TO_W'(1);
            w_to_fire  = !w_release && !bus.ack && (r_wdog == TO_W'(TIMEOUT - 1));
            w_release  = w_release || w_to_fire;
`endif
            if (w_release) begin
               w_state_nxt = IDLE;
               w_quota_nxt = '0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // In GRANT the last owner is the current owner, so grant outputs decode from it directly.
   always_comb begin
      bus.gnt       = '0;
      bus.gnt_idx   = '0;
      bus.gnt_valid = 1'b0;
      if (r_state == GRANT) begin
         bus.gnt[r_last] = 1'b1;
         bus.gnt_idx     = r_last;
         bus.gnt_valid   = 1'b1;
      end
`ifdef ARB_TIMEOUT_EN
      bus.timeout = r_timeout;
`else
      bus.timeout = 1'b0;
`endif
   end
endmodule

// File: tb/tb_wb_interconnect_arb_wrr.sv
// Randomized and directed bench for wb_interconnect_arb_wrr against a tenure-level reference model.
module tb_wb_interconnect_arb_wrr;
   localparam int N  = 4;
   localparam int WW = 4;
   localparam int TO = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   wb_interconnect_arb_wrr_if #(.N_REQ(N), .WEIGHT_W(WW)) bus ();

   wb_interconnect_arb_wrr #(.N_REQ(N), .WEIGHT_W(WW), .TIMEOUT(TO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Reference model: who owns the bus, how many acked transfers remain, who went last.
   int m_owner = -1;
   int m_last  = N - 1;
   int m_left  = 0;
   int m_idle  = 0;
   bit m_to    = 1'b0;

   function automatic logic [N*WW-1:0] pack_w(input int w0, input int w1, input int w2, input int w3);
      logic [N*WW-1:0] v;
      v = '0;
      v[0*WW +: WW] = WW'(w0);
      v[1*WW +: WW] = WW'(w1);
      v[2*WW +: WW] = WW'(w2);
      v[3*WW +: WW] = WW'(w3);
      return v;
   endfunction

   task automatic model_edge(input logic [N-1:0] rq, input logic [N*WW-1:0] wt, input logic ak, input logic rs);
      int  w;
      bit  done;
      if (rs) begin
         m_owner = -1; m_last = N - 1; m_left = 0; m_idle = 0; m_to = 1'b0;
      end else if (m_owner < 0) begin
         m_to = 1'b0;
         for (int k = 1; k <= N; k++) begin
            if (m_owner < 0 && rq[(m_last + k) % N]) begin
               m_owner = (m_last + k) % N;
               w       = int'(wt[m_owner*WW +: WW]);
               m_left  = (w == 0) ? 1 : w;
               m_idle  = 0;
            end
         end
         if (m_owner >= 0) m_last = m_owner;
      end else begin
         m_to = 1'b0;
         if (ak) m_left = m_left - 1;
         done = !rq[m_owner] || (ak && m_left == 0);
`ifdef ARB_TIMEOUT_EN
         if (!done && !ak && m_idle == TO - 1) begin
            done = 1'b1;
            m_to = 1'b1;
         end
`endif
         m_idle = ak ? 0 : m_idle + 1;
         if (done) m_owner = -1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] eg;
      eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      chk("gnt",       32'(bus.gnt),       32'(eg));
      chk("gnt_idx",   32'(bus.gnt_idx),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk("gnt_valid", 32'(bus.gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
      chk("timeout",   32'(bus.timeout),   32'(m_to));
   endtask

   // Drive one cycle of inputs, let the edge happen, then check on the falling edge.
   task automatic cycle(input logic [N-1:0] rq, input logic [N*WW-1:0] wt, input logic ak, input logic rs);
      bus.req    = rq;
      bus.weight = wt;
      bus.ack    = ak;
      reset      = rs;
      @(posedge clock);
      model_edge(rq, wt, ak, rs);
      @(negedge clock);
      check_outputs();
   endtask

   initial begin
      logic [N-1:0] rot_exp [10];
      logic [N-1:0] rq;
      rot_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
      bus.req = '0; bus.weight = '0; bus.ack = 1'b0;
      @(negedge clock);

      // Reset state
      cycle('0, '0, 1'b0, 1'b1);
      cycle('0, '0, 1'b0, 1'b1);
      cycle('0, '0, 1'b1, 1'b0);

      // All request, weight 1, ack always: grants rotate with a turnaround between each
      for (int i = 0; i < 10; i++) begin
         cycle(4'b1111, pack_w(1, 1, 1, 1), 1'b1, 1'b0);
         chk("rotation", 32'(bus.gnt), 32'(rot_exp[i]));
      end

      // Requester 0 weight 3, requester 2 weight 1
      cycle('0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) cycle(4'b0101, pack_w(3, 0, 1, 0), 1'b1, 1'b0);

      // Owner 1 with weight 5 drops req after two acks; next grant goes above 1
      cycle('0, '0, 1'b0, 1'b1);
      cycle(4'b0010, pack_w(1, 5, 1, 1), 1'b0, 1'b0);
      cycle(4'b1010, pack_w(1, 5, 1, 1), 1'b1, 1'b0);
      cycle(4'b1010, pack_w(1, 5, 1, 1), 1'b1, 1'b0);
      cycle(4'b1000, pack_w(1, 5, 1, 1), 1'b0, 1'b0);
      chk("drop_release", 32'(bus.gnt), 32'd0);
      cycle(4'b1000, pack_w(1, 5, 1, 1), 1'b0, 1'b0);
      chk("drop_next", 32'(bus.gnt), 32'b1000);

      // Zero weight loads as one transfer
      cycle('0, '0, 1'b0, 1'b1);
      cycle(4'b1000, pack_w(0, 0, 0, 0), 1'b0, 1'b0);
      cycle(4'b1000, pack_w(0, 0, 0, 0), 1'b1, 1'b0);
      chk("zero_weight", 32'(bus.gnt_valid), 32'd0);
      cycle(4'b1000, pack_w(0, 0, 0, 0), 1'b0, 1'b0);

      // Reset in GRANT, then re-grant one cycle after release of reset
      cycle(4'b0010, pack_w(4, 4, 4, 4), 1'b0, 1'b1);
      cycle(4'b0010, pack_w(4, 4, 4, 4), 1'b0, 1'b0);
      cycle(4'b0010, pack_w(4, 4, 4, 4), 1'b0, 1'b1);
      chk("reset_drop", 32'(bus.gnt), 32'd0);
      cycle(4'b0010, pack_w(4, 4, 4, 4), 1'b0, 1'b0);
      chk("reset_regrant", 32'(bus.gnt), 32'b0010);

`ifdef ARB_TIMEOUT_EN
      // Watchdog: single requester, never acked
      cycle('0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 24; i++) cycle(4'b0001, pack_w(2, 2, 2, 2), 1'b0, 1'b0);
`endif

      // Random traffic with occasional resets
      cycle('0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3000; i++) begin
         rq = N'($urandom);
         if ($urandom_range(0, 3) == 0) rq = '0;
         cycle(rq, (N*WW)'($urandom), 1'($urandom_range(0, 2) != 0), $urandom_range(0, 299) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
